timer_ctrl: RTL

//   Sequencing controller for a WIDTH-bit up-counter. Accepts start/abort commands,

---
 rtl/timer_pkg.sv | 15 +
 rtl/up_counter.sv | 25 ++
 rtl/timer_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencing controller and its counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default counter and prescaler widths.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/up_counter.sv
// WIDTH-bit up-counter datapath with synchronous clear.
// Latency: count updates on the edge after clear/enable are sampled.
// Backpressure: none; enable simply holds the value when low.
// Ports: clk, reset (sync, active-high), clear (priority over enable), enable, count.
module up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Start/abort sequencer for an up-counter: one-shot or auto-reload, busy/done status.
// Latency: busy rises one edge after start; done rises limit ticks after the start edge.
// Backpressure: none; start is ignored outside IDLE, abort always wins over start/terminal.
// Ports: clk, reset (sync, active-high), start, abort, periodic, limit, prescale
//        -> busy, done (1-cycle pulse), count.
// Build option: define TIMER_PRESCALE_EN to divide ticks by prescale+1;
//        otherwise prescale is unused and the counter ticks every cycle.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      count
);

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick;
  logic             launch;
  logic             advance;
  logic             terminal;
  logic             reload;
  logic             cnt_clear;
  logic             cnt_enable;

  // A start in IDLE always clears the count, even for limit==0 (done-only case).
  assign launch   = (state == IDLE) && start && !abort;
  assign advance  = (state == RUN) && tick && !abort;
  // limit_q is never 0 in RUN, so limit_q-1 cannot underflow here.
  assign terminal = advance && (count == limit_q - WIDTH'(1));
  // Periodic mode sits at limit_q for one tick, then reloads to 0.
  assign reload   = advance && periodic_q && (count == limit_q);

  assign cnt_clear  = launch || reload;
  assign cnt_enable = advance;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescaler;

  assign tick = (prescaler == prescale_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      prescale_q <= '0;
    end else if (state == IDLE) begin
      if (launch) begin
        prescaler  <= '0;
        prescale_q <= prescale;
      end
    end else if (abort || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESCALE_W'(1);
    end
  end
`else
  logic unused_prescale;

  assign tick            = 1'b1;
  assign unused_prescale = ^prescale;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (launch) begin
          if (limit != '0) begin
            limit_q    <= limit;
            periodic_q <= periodic;
            busy       <= 1'b1;
            state      <= RUN;
          end else begin
            // Zero terminal count: report completion immediately, never go busy.
            done <= 1'b1;
          end
        end
      end else begin
        if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (terminal) begin
          done <= 1'b1;
          if (!periodic_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

  up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

endmodule
